// File: rtl/apu_sample_fifo.sv
// apu_sample_fifo: box-average the unsigned APU mixer stream by 2^AVG_LOG2,
// convert offset-binary to two's complement, buffer in a small FIFO, and hand
// one signed sample per frame request to the serializer. A FILL/RUN state
// machine primes the FIFO to half depth before real samples are released.
module apu_sample_fifo #(
    parameter int unsigned IN_WIDTH   = 16,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned AVG_LOG2   = 5,
    parameter int unsigned FIFO_AW    = 4
) (
    input  logic                  iCLK_18_4,
    input  logic                  iRST,
    input  logic [IN_WIDTH-1:0]   iSample,
    input  logic                  iSample_Valid,
    input  logic                  iReq,
    input  logic                  iClear_Flags,
    output logic [DATA_WIDTH-1:0] oSample,
    output logic                  oSample_Ack,
    output logic [FIFO_AW:0]      oLevel,
    output logic                  oOverflow,
    output logic                  oUnderflow
);

    localparam int unsigned ACC_W = IN_WIDTH + AVG_LOG2;
    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned HALF  = DEPTH / 2;
    localparam int unsigned LVL_W = FIFO_AW + 1;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Averager
    // ------------------------------------------------------------------
    logic [ACC_W-1:0]      r_acc;
    logic [AVG_LOG2-1:0]   r_cnt;
    logic [DATA_WIDTH-1:0] r_avg;
    logic                  r_avg_vld;

    logic [ACC_W-1:0]      w_sum;
    logic                  w_last;
    logic [IN_WIDTH-1:0]   w_avg;
    logic [IN_WIDTH-1:0]   w_tc;
    logic [DATA_WIDTH-1:0] w_conv;

    assign w_sum  = r_acc + ACC_W'(iSample);
    assign w_last = iSample_Valid && (r_cnt == {AVG_LOG2{1'b1}});
    // Accumulator is wide enough that the top IN_WIDTH bits are the truncated mean.
    assign w_avg  = w_sum[ACC_W-1:AVG_LOG2];
    // Flipping the MSB turns offset-binary into two's complement.
    assign w_tc   = {~w_avg[IN_WIDTH-1], w_avg[IN_WIDTH-2:0]};

    // Width adaptation: left-justify when widening, drop LSBs when narrowing.
    generate
        if (DATA_WIDTH > IN_WIDTH) begin : g_widen
            assign w_conv = {w_tc, {(DATA_WIDTH-IN_WIDTH){1'b0}}};
        end else if (DATA_WIDTH < IN_WIDTH) begin : g_narrow
            assign w_conv = w_tc[IN_WIDTH-1 -: DATA_WIDTH];
        end else begin : g_same
            assign w_conv = w_tc;
        end
    endgenerate

    // Accumulate strobed samples; latch the converted mean on the final strobe.
    always_ff @(posedge iCLK_18_4) begin
        if (iRST) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_avg     <= '0;
            r_avg_vld <= 1'b0;
        end else begin
            r_avg_vld <= w_last;
            if (iSample_Valid) begin
                if (w_last) begin
                    r_acc <= '0;
                    r_cnt <= '0;
                    r_avg <= w_conv;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + AVG_LOG2'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage and control
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [FIFO_AW-1:0]    r_wr_ptr;
    logic [FIFO_AW-1:0]    r_rd_ptr;
    logic [LVL_W-1:0]      r_level;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push_ok;
    logic                  w_ovf_evt;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_pop;
    logic                  w_unf_evt;
    logic                  w_silence;

    assign w_full    = (r_level == LVL_W'(DEPTH));
    assign w_empty   = (r_level == '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign w_push_ok = r_avg_vld && (!w_full || w_pop);
    assign w_ovf_evt = r_avg_vld && w_full && !w_pop;

    // State register.
    always_ff @(posedge iCLK_18_4) begin
        if (iRST) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and request decode: FILL answers with silence until half full.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_unf_evt   = 1'b0;
        w_silence   = 1'b0;
        case (r_state)
            ST_FILL: begin
                w_silence = iReq;
                if (r_level >= LVL_W'(HALF)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (iReq) begin
                    if (w_empty) begin
                        w_unf_evt   = 1'b1;
                        w_state_nxt = ST_FILL;
                    end else begin
                        w_pop = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_FILL;
            end
        endcase
    end

    // Sample storage; not reset, contents are only read behind a valid level.
    always_ff @(posedge iCLK_18_4) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= r_avg;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at the depth.
    always_ff @(posedge iCLK_18_4) begin
        if (iRST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Serializer handshake and debug flags
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_sample;
    logic                  r_ack;
    logic                  r_ovf;
    logic                  r_unf;

    // Output sample: silence in FILL, head of FIFO on a pop, hold otherwise.
    always_ff @(posedge iCLK_18_4) begin
        if (iRST) begin
            r_sample <= '0;
            r_ack    <= 1'b0;
        end else begin
            r_ack <= iReq;
            if (w_silence) begin
                r_sample <= '0;
            end else if (w_pop) begin
                r_sample <= r_mem[r_rd_ptr];
            end
        end
    end

    // Sticky flags; a new event takes priority over a coincident clear.
    always_ff @(posedge iCLK_18_4) begin
        if (iRST) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (w_ovf_evt) begin
                r_ovf <= 1'b1;
            end else if (iClear_Flags) begin
                r_ovf <= 1'b0;
            end
            if (w_unf_evt) begin
                r_unf <= 1'b1;
            end else if (iClear_Flags) begin
                r_unf <= 1'b0;
            end
        end
    end

    assign oSample     = r_sample;
    assign oSample_Ack = r_ack;
    assign oLevel      = r_level;
    assign oOverflow   = r_ovf;
    assign oUnderflow  = r_unf;

endmodule

// File: tb/tb_apu_sample_fifo.sv
// Directed bench for apu_sample_fifo: averaging, conversion, FIFO ordering,
// prime/refill behaviour and sticky flags.
module tb_apu_sample_fifo;

    logic        clk = 1'b0;
    logic        iRST;
    logic [15:0] iSample;
    logic        iSample_Valid;
    logic        iReq;
    logic        iClear_Flags;
    logic [15:0] oSample;
    logic        oSample_Ack;
    logic [4:0]  oLevel;
    logic        oOverflow;
    logic        oUnderflow;

    int n_checks = 0;
    int n_fail   = 0;

    apu_sample_fifo dut (
        .iCLK_18_4     (clk),
        .iRST          (iRST),
        .iSample       (iSample),
        .iSample_Valid (iSample_Valid),
        .iReq          (iReq),
        .iClear_Flags  (iClear_Flags),
        .oSample       (oSample),
        .oSample_Ack   (oSample_Ack),
        .oLevel        (oLevel),
        .oOverflow     (oOverflow),
        .oUnderflow    (oUnderflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [15:0] v);
        iSample       = v;
        iSample_Valid = 1'b1;
        tick();
        iSample_Valid = 1'b0;
    endtask

    // 32 strobes of v, then one cycle so the averaged push has landed.
    task automatic push_avg(input logic [15:0] v);
        for (int i = 0; i < 32; i++) strobe(v);
        tick();
    endtask

    task automatic do_reset();
        iRST = 1'b1;
        tick();
        tick();
        iRST = 1'b0;
    endtask

    // Single-cycle request; returns with the acknowledge cycle visible.
    task automatic req();
        iReq = 1'b1;
        tick();
        iReq = 1'b0;
    endtask

    task automatic test_reset();
        iRST = 1'b1;
        tick();
        tick();
        n_checks++; if (oSample !== 16'h0000) begin n_fail++; $display("FAIL reset_sample got=%h exp=0000", oSample); end
        n_checks++; if (oSample_Ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got=%b exp=0", oSample_Ack); end
        n_checks++; if (oLevel !== 5'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", oLevel); end
        n_checks++; if (oOverflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", oOverflow); end
        n_checks++; if (oUnderflow !== 1'b0) begin n_fail++; $display("FAIL reset_unf got=%b exp=0", oUnderflow); end
        iRST = 1'b0;
        tick();
    endtask

    task automatic test_silence();
        do_reset();
        for (int i = 0; i < 32; i++) strobe(16'h8000);
        n_checks++; if (oLevel !== 5'd0) begin n_fail++; $display("FAIL silence_latency got=%0d exp=0", oLevel); end
        tick();
        n_checks++; if (oLevel !== 5'd1) begin n_fail++; $display("FAIL silence_level got=%0d exp=1", oLevel); end
        req();
        n_checks++; if (oSample_Ack !== 1'b1) begin n_fail++; $display("FAIL silence_ack got=%b exp=1", oSample_Ack); end
        n_checks++; if (oSample !== 16'h0000) begin n_fail++; $display("FAIL silence_sample got=%h exp=0000", oSample); end
        n_checks++; if (oLevel !== 5'd1) begin n_fail++; $display("FAIL silence_nopop got=%0d exp=1", oLevel); end
        n_checks++; if (oUnderflow !== 1'b0 || oOverflow !== 1'b0) begin n_fail++; $display("FAIL silence_flags got=%b%b exp=00", oOverflow, oUnderflow); end
        tick();
        n_checks++; if (oSample_Ack !== 1'b0) begin n_fail++; $display("FAIL silence_ack_pulse got=%b exp=0", oSample_Ack); end
        // Fill to half and confirm the stored value was 0x0000.
        for (int i = 0; i < 7; i++) push_avg(16'h9000);
        tick();
        req();
        n_checks++; if (oSample !== 16'h0000) begin n_fail++; $display("FAIL silence_stored got=%h exp=0000", oSample); end
        req();
        n_checks++; if (oSample !== 16'h1000) begin n_fail++; $display("FAIL silence_next got=%h exp=1000", oSample); end
    endtask

    task automatic test_conversion_order();
        logic [15:0] exp_v [8];
        exp_v[0] = 16'h7FFF; exp_v[1] = 16'h8001; exp_v[2] = 16'h8000; exp_v[3] = 16'h9000;
        exp_v[4] = 16'hA000; exp_v[5] = 16'hB000; exp_v[6] = 16'hD000; exp_v[7] = 16'hE000;
        do_reset();
        push_avg(16'hFFFF);
        for (int i = 0; i < 16; i++) begin strobe(16'h0000); strobe(16'h0003); end
        tick();
        for (int i = 0; i < 31; i++) strobe(16'h0000);
        strobe(16'h001F);
        tick();
        push_avg(16'h1000);
        push_avg(16'h2000);
        push_avg(16'h3000);
        push_avg(16'h5000);
        push_avg(16'h6000);
        n_checks++; if (oLevel !== 5'd8) begin n_fail++; $display("FAIL order_level8 got=%0d exp=8", oLevel); end
        tick();
        for (int i = 0; i < 8; i++) begin
            req();
            n_checks++; if (oSample !== exp_v[i]) begin n_fail++; $display("FAIL order_sample%0d got=%h exp=%h", i, oSample, exp_v[i]); end
            n_checks++; if (oLevel !== 5'(7 - i)) begin n_fail++; $display("FAIL order_level%0d got=%0d exp=%0d", i, oLevel, 7 - i); end
        end
    endtask

    task automatic test_overflow_underflow();
        do_reset();
        for (int k = 0; k < 16; k++) push_avg(16'(k * 16'h0400));
        n_checks++; if (oLevel !== 5'd16 || oOverflow !== 1'b0) begin n_fail++; $display("FAIL ovf_full got=%0d/%b exp=16/0", oLevel, oOverflow); end
        push_avg(16'h4000);
        n_checks++; if (oLevel !== 5'd16) begin n_fail++; $display("FAIL ovf_level got=%0d exp=16", oLevel); end
        n_checks++; if (oOverflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got=%b exp=1", oOverflow); end
        for (int k = 0; k < 16; k++) begin
            req();
            n_checks++; if (oSample !== 16'(16'h8000 + k * 16'h0400)) begin n_fail++; $display("FAIL ovf_drain%0d got=%h exp=%h", k, oSample, 16'(16'h8000 + k * 16'h0400)); end
        end
        n_checks++; if (oLevel !== 5'd0) begin n_fail++; $display("FAIL ovf_empty got=%0d exp=0", oLevel); end
        iClear_Flags = 1'b1;
        tick();
        iClear_Flags = 1'b0;
        n_checks++; if (oOverflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got=%b exp=0", oOverflow); end
        // Underflow: still in RUN with an empty FIFO.
        req();
        n_checks++; if (oSample !== 16'hBC00) begin n_fail++; $display("FAIL unf_hold got=%h exp=BC00", oSample); end
        n_checks++; if (oUnderflow !== 1'b1) begin n_fail++; $display("FAIL unf_flag got=%b exp=1", oUnderflow); end
        n_checks++; if (oSample_Ack !== 1'b1) begin n_fail++; $display("FAIL unf_ack got=%b exp=1", oSample_Ack); end
        req();
        n_checks++; if (oSample !== 16'h0000) begin n_fail++; $display("FAIL unf_refill got=%h exp=0000", oSample); end
        iClear_Flags = 1'b1;
        tick();
        iClear_Flags = 1'b0;
        n_checks++; if (oUnderflow !== 1'b0) begin n_fail++; $display("FAIL unf_clear got=%b exp=0", oUnderflow); end
    endtask

    task automatic test_full_simul();
        do_reset();
        for (int k = 1; k <= 16; k++) push_avg(16'(k * 16'h0100));
        for (int i = 0; i < 32; i++) strobe(16'h7000);
        iReq = 1'b1;
        tick();
        iReq = 1'b0;
        n_checks++; if (oSample !== 16'h8100) begin n_fail++; $display("FAIL simul_head got=%h exp=8100", oSample); end
        n_checks++; if (oLevel !== 5'd16) begin n_fail++; $display("FAIL simul_level got=%0d exp=16", oLevel); end
        n_checks++; if (oOverflow !== 1'b0) begin n_fail++; $display("FAIL simul_ovf got=%b exp=0", oOverflow); end
        for (int k = 2; k <= 16; k++) begin
            req();
            n_checks++; if (oSample !== 16'(16'h8000 + k * 16'h0100)) begin n_fail++; $display("FAIL simul_drain%0d got=%h exp=%h", k, oSample, 16'(16'h8000 + k * 16'h0100)); end
        end
        req();
        n_checks++; if (oSample !== 16'hF000) begin n_fail++; $display("FAIL simul_tail got=%h exp=F000", oSample); end
        n_checks++; if (oLevel !== 5'd0) begin n_fail++; $display("FAIL simul_empty got=%0d exp=0", oLevel); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 10; i++) strobe(16'h1234);
        iRST = 1'b1;
        tick();
        iRST = 1'b0;
        for (int i = 0; i < 32; i++) strobe(16'h4000);
        n_checks++; if (oLevel !== 5'd0) begin n_fail++; $display("FAIL mid_early got=%0d exp=0", oLevel); end
        tick();
        n_checks++; if (oLevel !== 5'd1) begin n_fail++; $display("FAIL mid_one got=%0d exp=1", oLevel); end
        for (int i = 0; i < 40; i++) tick();
        n_checks++; if (oLevel !== 5'd1) begin n_fail++; $display("FAIL mid_only got=%0d exp=1", oLevel); end
        for (int i = 0; i < 7; i++) push_avg(16'h8000);
        tick();
        req();
        n_checks++; if (oSample !== 16'hC000) begin n_fail++; $display("FAIL mid_value got=%h exp=C000", oSample); end
    endtask

    task automatic test_clear_coincident();
        do_reset();
        for (int i = 0; i < 16; i++) push_avg(16'h8000);
        for (int i = 0; i < 32; i++) strobe(16'h8000);
        iClear_Flags = 1'b1;
        tick();
        iClear_Flags = 1'b0;
        n_checks++; if (oOverflow !== 1'b1) begin n_fail++; $display("FAIL clr_coinc got=%b exp=1", oOverflow); end
        n_checks++; if (oLevel !== 5'd16) begin n_fail++; $display("FAIL clr_level got=%0d exp=16", oLevel); end
    endtask

    initial begin
        iRST          = 1'b1;
        iSample       = '0;
        iSample_Valid = 1'b0;
        iReq          = 1'b0;
        iClear_Flags  = 1'b0;
        test_reset();
        test_silence();
        test_conversion_order();
        test_overflow_underflow();
        test_full_simul();
        test_reset_mid();
        test_clear_coincident();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
